// File: rtl/range_mask_gen.sv
// Range/one-hot/thermometer mask generator with valid/ready command and beat streams.
// Optional RANGE_MASK_GEN_POPCOUNT_EN adds out_cnt, the population count of out_mask.
module range_mask_gen #(
  parameter int IDX_W = 5,
  parameter int OUT_W = 2 ** IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IDX_W-1:0] in_lo,
  input  logic [IDX_W-1:0] in_hi,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_mask,
`ifdef RANGE_MASK_GEN_POPCOUNT_EN
  output logic [IDX_W:0]   out_cnt,
`endif
  output logic             out_last
);

  typedef enum logic [1:0] {IDLE, HOLD, SWEEP} state_t;

  state_t           state_reg, state_next;
  logic [OUT_W-1:0] mask_reg, mask_next;
  logic             last_reg, last_next;
  logic [IDX_W-1:0] cur_reg, cur_next;
  logic [IDX_W-1:0] hi_reg, hi_next;

  logic [IDX_W-1:0] cur_inc;
  logic [OUT_W-1:0] ge_lo, le_lo, le_hi, onehot_lo, onehot_inc;
  logic [OUT_W-1:0] range_mask, load_mask;
  logic             hs, accept;

  assign cur_inc = cur_reg + IDX_W'(1);

  // Per-bit index comparisons; every mask shape is built from these.
  genvar gi;
  generate
    for (gi = 0; gi < OUT_W; gi++) begin : g_bit
      localparam logic [IDX_W-1:0] BIT_IDX = IDX_W'(gi);
      assign ge_lo[gi]      = (BIT_IDX >= in_lo);
      assign le_lo[gi]      = (BIT_IDX <= in_lo);
      assign le_hi[gi]      = (BIT_IDX <= in_hi);
      assign onehot_lo[gi]  = (BIT_IDX == in_lo);
      assign onehot_inc[gi] = (BIT_IDX == cur_inc);
    end
  endgenerate

  // lo > hi wraps around the top of the mask.
  assign range_mask = (in_lo <= in_hi) ? (ge_lo & le_hi) : (ge_lo | le_hi);

  always_comb begin
    load_mask = onehot_lo;
    case (in_mode)
      2'd1:    load_mask = le_lo;
      2'd2:    load_mask = range_mask;
      default: load_mask = onehot_lo;
    endcase
  end

  assign out_valid = (state_reg != IDLE);
  assign out_mask  = mask_reg;
  assign out_last  = last_reg;
  assign hs        = out_valid & out_ready;
  assign in_ready  = (state_reg == IDLE) | (hs & last_reg);
  assign accept    = in_valid & in_ready;

  always_comb begin
    state_next = state_reg;
    mask_next  = mask_reg;
    last_next  = last_reg;
    cur_next   = cur_reg;
    hi_next    = hi_reg;
    if (accept) begin
      cur_next = in_lo;
      hi_next  = in_hi;
      if (in_mode == 2'd3) begin
        state_next = SWEEP;
        mask_next  = onehot_lo;
        last_next  = (in_lo == in_hi);
      end else begin
        state_next = HOLD;
        mask_next  = load_mask;
        last_next  = 1'b1;
      end
    end else if (hs) begin
      if (last_reg) begin
        state_next = IDLE;
        mask_next  = '0;
        last_next  = 1'b0;
      end else begin
        cur_next  = cur_inc;
        mask_next = onehot_inc;
        last_next = (cur_inc == hi_reg);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      mask_reg  <= '0;
      last_reg  <= 1'b0;
      cur_reg   <= '0;
      hi_reg    <= '0;
    end else begin
      state_reg <= state_next;
      mask_reg  <= mask_next;
      last_reg  <= last_next;
      cur_reg   <= cur_next;
      hi_reg    <= hi_next;
    end
  end

`ifdef RANGE_MASK_GEN_POPCOUNT_EN
  logic [IDX_W:0] cnt_reg, cnt_next;

  always_comb begin
    cnt_next = '0;
    for (int i = 0; i < OUT_W; i++) begin
      cnt_next = cnt_next + {{IDX_W{1'b0}}, mask_next[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign out_cnt = cnt_reg;
`endif

endmodule

// File: tb/tb_range_mask_gen.sv
// Self-checking bench for range_mask_gen: directed vectors, corner sequences, and
// randomized traffic against a beat-queue reference model.
module tb_range_mask_gen;
  localparam int IDX_W = 5;
  localparam int OUT_W = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [IDX_W-1:0] in_lo;
  logic [IDX_W-1:0] in_hi;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_mask;
  logic             out_last;
`ifdef RANGE_MASK_GEN_POPCOUNT_EN
  logic [IDX_W:0]   out_cnt;
`endif

  int total = 0;
  int bad   = 0;

  range_mask_gen #(.IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_lo(in_lo), .in_hi(in_hi), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_mask(out_mask),
`ifdef RANGE_MASK_GEN_POPCOUNT_EN
    .out_cnt(out_cnt),
`endif
    .out_last(out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]       mode;
    logic [IDX_W-1:0] lo;
    logic [IDX_W-1:0] hi;
    logic [OUT_W-1:0] mask;
  } vec_t;

  typedef struct packed {
    logic [OUT_W-1:0] mask;
    logic             last;
  } beat_t;

  vec_t  vecs[11];
  beat_t exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] m, input logic [IDX_W-1:0] lo,
                       input logic [IDX_W-1:0] hi, input logic ordy);
    in_valid  = v;
    in_mode   = m;
    in_lo     = lo;
    in_hi     = hi;
    out_ready = ordy;
  endtask

  task automatic chk_cnt(input string name, input logic [OUT_W-1:0] exp_mask);
`ifdef RANGE_MASK_GEN_POPCOUNT_EN
    chk(name, 64'(out_cnt), 64'($countones(exp_mask)));
`else
    if (exp_mask === 'x) $display("unreachable %s", name);
`endif
  endtask

  // Reference: expand a command into its full list of beats from the mode rules.
  function automatic void push_cmd(input logic [1:0] m, input int lo, input int hi);
    beat_t b;
    int    n;
    if (m == 2'd3) begin
      n = (((hi - lo) % OUT_W) + OUT_W) % OUT_W + 1;
      for (int k = 0; k < n; k++) begin
        b.mask = '0;
        b.mask[(lo + k) % OUT_W] = 1'b1;
        b.last = (k == n - 1);
        exp_q.push_back(b);
      end
    end else begin
      b.mask = '0;
      for (int i = 0; i < OUT_W; i++) begin
        case (m)
          2'd0: b.mask[i] = (i == lo);
          2'd1: b.mask[i] = (i <= lo);
          default: b.mask[i] = (lo <= hi) ? (i >= lo && i <= hi) : (i >= lo || i <= hi);
        endcase
      end
      b.last = 1'b1;
      exp_q.push_back(b);
    end
  endfunction

  initial begin
    logic [OUT_W-1:0] sweep_exp[4];
    logic             exp_rdy;
    logic             exp_v;

    vecs[0]  = '{2'd2, 5'd3,  5'd6,  32'h0000_0078};
    vecs[1]  = '{2'd2, 5'd30, 5'd1,  32'hC000_0003};
    vecs[2]  = '{2'd1, 5'd31, 5'd9,  32'hFFFF_FFFF};
    vecs[3]  = '{2'd1, 5'd0,  5'd20, 32'h0000_0001};
    vecs[4]  = '{2'd0, 5'd4,  5'd17, 32'h0000_0010};
    vecs[5]  = '{2'd2, 5'd5,  5'd5,  32'h0000_0020};
    vecs[6]  = '{2'd2, 5'd0,  5'd31, 32'hFFFF_FFFF};
    vecs[7]  = '{2'd2, 5'd31, 5'd0,  32'h8000_0001};
    vecs[8]  = '{2'd0, 5'd31, 5'd3,  32'h8000_0000};
    vecs[9]  = '{2'd1, 5'd7,  5'd2,  32'h0000_00FF};
    vecs[10] = '{2'd3, 5'd9,  5'd9,  32'h0000_0200};

    rst = 1'b1;
    drive(1'b0, 2'd0, '0, '0, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_valid", 64'(out_valid), 64'd0);
    chk("reset_mask",  64'(out_mask),  64'd0);
    chk("reset_last",  64'(out_last),  64'd0);
    chk("reset_ready", 64'(in_ready),  64'd1);
    chk_cnt("reset_cnt", '0);

    // Single-beat vectors issued from IDLE.
    for (int v = 0; v < 11; v++) begin
      @(negedge clk);
      drive(1'b1, vecs[v].mode, vecs[v].lo, vecs[v].hi, 1'b1);
      #1 chk("vec_ready", 64'(in_ready), 64'd1);
      @(negedge clk);
      drive(1'b0, 2'd0, '0, '0, 1'b1);
      #1;
      $display("vec %0d mode=%0d lo=%0d hi=%0d mask=%h last=%0d", v, vecs[v].mode,
               vecs[v].lo, vecs[v].hi, out_mask, out_last);
      chk("vec_valid", 64'(out_valid), 64'd1);
      chk("vec_mask",  64'(out_mask),  64'(vecs[v].mask));
      chk("vec_last",  64'(out_last),  64'd1);
      chk_cnt("vec_cnt", vecs[v].mask);
      @(negedge clk);
      #1 chk("vec_idle", 64'(out_valid), 64'd0);
    end

    // Wrapping sweep with out_ready toggling.
    sweep_exp[0] = 32'h4000_0000;
    sweep_exp[1] = 32'h8000_0000;
    sweep_exp[2] = 32'h0000_0001;
    sweep_exp[3] = 32'h0000_0002;
    @(negedge clk);
    drive(1'b1, 2'd3, 5'd30, 5'd1, 1'b1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive(1'b0, 2'd0, '0, '0, 1'b0);
      #1;
      $display("sweep beat %0d mask=%h last=%0d", k, out_mask, out_last);
      chk("sweep_valid", 64'(out_valid), 64'd1);
      chk("sweep_mask",  64'(out_mask),  64'(sweep_exp[k]));
      chk("sweep_last",  64'(out_last),  64'(k == 3));
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      chk("sweep_stall_mask", 64'(out_mask), 64'(sweep_exp[k]));
      chk("sweep_stall_last", 64'(out_last), 64'(k == 3));
    end
    @(negedge clk);
    out_ready = 1'b0;
    #1 chk("sweep_done", 64'(out_valid), 64'd0);

    // Back-to-back one-hot commands.
    @(negedge clk);
    drive(1'b1, 2'd0, 5'd4, 5'd0, 1'b1);
    @(negedge clk);
    drive(1'b1, 2'd0, 5'd9, 5'd0, 1'b1);
    #1;
    chk("b2b_valid0", 64'(out_valid), 64'd1);
    chk("b2b_mask0",  64'(out_mask),  64'h10);
    chk("b2b_ready0", 64'(in_ready),  64'd1);
    @(negedge clk);
    drive(1'b0, 2'd0, '0, '0, 1'b1);
    #1;
    chk("b2b_valid1", 64'(out_valid), 64'd1);
    chk("b2b_mask1",  64'(out_mask),  64'h200);
    $display("b2b second beat mask=%h", out_mask);
    @(negedge clk);
    #1 chk("b2b_idle", 64'(out_valid), 64'd0);

    // Reset during sweep beat 2.
    @(negedge clk);
    drive(1'b1, 2'd3, 5'd0, 5'd7, 1'b1);
    @(negedge clk);
    drive(1'b0, 2'd0, '0, '0, 1'b1);
    #1 chk("rst_beat1", 64'(out_mask), 64'h1);
    @(negedge clk);
    #1 chk("rst_beat2", 64'(out_mask), 64'h2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_mask",  64'(out_mask),  64'd0);
    chk("rst_ready", 64'(in_ready),  64'd1);
    @(negedge clk);
    #1 chk("rst_no_beat3", 64'(out_valid), 64'd0);
    $display("reset mid-sweep done");

    // Command offered while holding a stalled beat is ignored.
    @(negedge clk);
    drive(1'b1, 2'd2, 5'd3, 5'd6, 1'b0);
    @(negedge clk);
    drive(1'b1, 2'd0, 5'd20, 5'd0, 1'b0);
    #1;
    chk("stall_ready", 64'(in_ready), 64'd0);
    chk("stall_mask0", 64'(out_mask), 64'h78);
    @(negedge clk);
    #1 chk("stall_mask1", 64'(out_mask), 64'h78);
    drive(1'b0, 2'd0, '0, '0, 1'b1);
    @(negedge clk);
    #1 chk("stall_not_captured", 64'(out_valid), 64'd0);
    $display("stall ignore done");

    // Randomized traffic against the beat-queue model.
    exp_q.delete();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 149) == 0);
      drive($urandom_range(0, 9) < 6, 2'($urandom_range(0, 3)), IDX_W'($urandom),
            IDX_W'($urandom), $urandom_range(0, 9) < 7);
      #1;
      exp_v   = (exp_q.size() != 0);
      exp_rdy = !exp_v || (out_ready && exp_q.size() == 1);
      chk("rnd_valid", 64'(out_valid), 64'(exp_v));
      chk("rnd_ready", 64'(in_ready),  64'(exp_rdy));
      if (exp_v) begin
        chk("rnd_mask", 64'(out_mask), 64'(exp_q[0].mask));
        chk("rnd_last", 64'(out_last), 64'(exp_q[0].last));
        chk_cnt("rnd_cnt", exp_q[0].mask);
      end
      if (rst) begin
        exp_q.delete();
      end else begin
        if (exp_v && out_ready) void'(exp_q.pop_front());
        if (in_valid && exp_rdy) push_cmd(in_mode, int'(in_lo), int'(in_hi));
      end
    end
    rst = 1'b0;
    $display("random phase complete");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
